// File: rtl/sigpulse_seq_pkg.sv
// Shared types and defaults for the sigpulse burst sequencer.
package sigpulse_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FIRE = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_STOP = 3'd4
  } state_e;

  localparam int WDOG_SLACK_DEFAULT = 16;

endpackage

// File: rtl/seq_cnt.sv
// Saturating up-counter with clear, shared by the gap timer and the watchdog.
// o_hit flags the cycle in which the count reaches i_target.
module seq_cnt
  import sigpulse_seq_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_target,
  output logic         o_hit
);

  localparam logic [W:0] ONE = (W+1)'(1);

  logic [W-1:0] r_cnt;
  logic [W:0]   w_cnt_p1;

  assign w_cnt_p1 = {1'b0, r_cnt} + ONE;

  // The current cycle is the i_target-th counted one, so the caller can
  // leave its state on this edge without an extra cycle of latency.
  assign o_hit = (w_cnt_p1 >= {1'b0, i_target});

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= w_cnt_p1[W-1:0];
    end
  end

endmodule

// File: rtl/sigpulse_seq.sv
// Burst sequencer for one sigpulse channel: strobes the channel, counts pulse
// completions, spaces pulses by a gap and ends bursts on abort or watchdog.
module sigpulse_seq
  import sigpulse_seq_pkg::*;
#(
  parameter int _RAM_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int WDOG_SLACK = WDOG_SLACK_DEFAULT
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [_RAM_WIDTH-1:0] cfg_pulseWidth,
  input  logic [_RAM_WIDTH-1:0] cfg_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  cfg_defaultLevel,
  output logic                  sp_en,
  output logic                  sp_pwm_dis,
  output logic [_RAM_WIDTH-1:0] sp_pulseWidth,
  output logic                  sp_defaultLevel,
  input  logic                  sp_pulse_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  pulse_idx
);

  localparam int CW = _RAM_WIDTH + 1;

  state_e r_state;
  state_e w_next_state;

  logic [_RAM_WIDTH-1:0] r_width;
  logic [_RAM_WIDTH-1:0] r_gap;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_pulse_idx;
  logic                  r_default_level;

  logic r_sp_en;
  logic r_pwm_dis;
  logic r_done;
  logic r_aborted;
  logic r_timeout;

  logic                 w_latch_cfg;
  logic                 w_idx_inc;
  logic                 w_done_normal;
  logic                 w_wdog_trip;
  logic [CNT_WIDTH-1:0] w_idx_plus1;
  logic [CW-1:0]        w_wdog_limit;
  logic [CW-1:0]        w_cnt_target;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_cnt_hit;

  assign w_idx_plus1  = r_pulse_idx + CNT_WIDTH'(1);
  assign w_wdog_limit = CW'(r_width) + CW'(WDOG_SLACK);

  // One counter serves both timers: only one of GAP/WAIT is ever active, and
  // it restarts from zero on every state change.
  assign w_cnt_target = (r_state == ST_GAP) ? CW'(r_gap) : w_wdog_limit;
  assign w_cnt_clr    = (r_state != w_next_state);
  assign w_cnt_inc    = (r_state == ST_WAIT) || (r_state == ST_GAP);

  seq_cnt #(
    .W (CW)
  ) u_seq_cnt (
    .clk      (io_clk),
    .rst_n    (io_rst),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .i_target (w_cnt_target),
    .o_hit    (w_cnt_hit)
  );

  always_ff @(posedge io_clk) begin
    if (!io_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_latch_cfg   = 1'b0;
    w_idx_inc     = 1'b0;
    w_done_normal = 1'b0;
    w_wdog_trip   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_latch_cfg = 1'b1;
          if (cfg_count == '0) begin
            w_done_normal = 1'b1;
          end else begin
            w_next_state = ST_FIRE;
          end
        end
      end

      ST_FIRE: begin
        w_next_state = cfg_abort ? ST_STOP : ST_WAIT;
      end

      // Abort outranks a coincident completion, which is then not counted.
      ST_WAIT: begin
        if (cfg_abort) begin
          w_next_state = ST_STOP;
        end else if (sp_pulse_valid) begin
          w_idx_inc = 1'b1;
          if (w_idx_plus1 == r_count) begin
            w_next_state  = ST_IDLE;
            w_done_normal = 1'b1;
          end else if (r_gap == '0) begin
            w_next_state = ST_FIRE;
          end else begin
            w_next_state = ST_GAP;
          end
        end else if (w_cnt_hit) begin
          w_next_state = ST_STOP;
          w_wdog_trip  = 1'b1;
        end
      end

      ST_GAP: begin
        if (cfg_abort) begin
          w_next_state = ST_STOP;
        end else if (w_cnt_hit) begin
          w_next_state = ST_FIRE;
        end
      end

      ST_STOP: begin
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered against the next state so they line up with the
  // cycle the FSM actually occupies FIRE or STOP.
  always_ff @(posedge io_clk) begin
    if (!io_rst) begin
      r_width         <= '0;
      r_gap           <= '0;
      r_count         <= '0;
      r_default_level <= 1'b0;
      r_pulse_idx     <= '0;
      r_sp_en         <= 1'b0;
      r_pwm_dis       <= 1'b0;
      r_done          <= 1'b0;
      r_aborted       <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      if (w_latch_cfg) begin
        r_width         <= cfg_pulseWidth;
        r_gap           <= cfg_gap;
        r_count         <= cfg_count;
        r_default_level <= cfg_defaultLevel;
        r_pulse_idx     <= '0;
      end else if (w_idx_inc) begin
        r_pulse_idx <= w_idx_plus1;
      end

      r_sp_en   <= (w_next_state == ST_FIRE);
      r_pwm_dis <= (w_next_state == ST_STOP);
      r_done    <= (w_next_state == ST_STOP) || w_done_normal;
      r_aborted <= (w_next_state == ST_STOP);
      r_timeout <= w_wdog_trip;
    end
  end

  assign sp_en           = r_sp_en;
  assign sp_pwm_dis      = r_pwm_dis;
  assign sp_pulseWidth   = r_width;
  assign sp_defaultLevel = r_default_level;
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;
  assign aborted         = r_aborted;
  assign timeout         = r_timeout;
  assign pulse_idx       = r_pulse_idx;

endmodule
